// File: rtl/control_pkg.sv
// Shared encodings for the JALA stack-CPU control unit.
package control_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned STATE_W = 5;

  // Opcodes, IROut[15:12]
  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_ALU   = 4'h1;
  localparam logic [OPC_W-1:0] OP_PUSHI = 4'h2;
  localparam logic [OPC_W-1:0] OP_POP   = 4'h3;
  localparam logic [OPC_W-1:0] OP_JPOP  = 4'h4;
  localparam logic [OPC_W-1:0] OP_BRZ   = 4'h5;
  localparam logic [OPC_W-1:0] OP_CALL  = 4'h6;
  localparam logic [OPC_W-1:0] OP_RET   = 4'h7;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

  // Memory address selects (2'b10 selects ValA; no micro-step uses it yet)
  localparam logic [1:0] DST_PC_MSP  = 2'b00;
  localparam logic [1:0] DST_MSP_RSP = 2'b01;

  // Memory write-data selects
  localparam logic [1:0] DATA_VALA = 2'b00;
  localparam logic [1:0] DATA_ZEXT = 2'b01;
  localparam logic [1:0] DATA_RES  = 2'b10;
  localparam logic [1:0] DATA_PC   = 2'b11;

  localparam logic [2:0] ALUOP_DEFAULT = 3'b000;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT,
    ST_FETCH1,
    ST_FETCH2,
    ST_DECODE,
    ST_ALU1,
    ST_ALU2,
    ST_ALU3,
    ST_PSH1,
    ST_PSH2,
    ST_POP1,
    ST_JP1,
    ST_BR1,
    ST_CL1,
    ST_CL2,
    ST_RT1,
    ST_RT2,
    ST_RT3,
    ST_HALT
  } state_t;

  // Control word driven towards the datapath
  typedef struct packed {
    logic       msp_write;
    logic       msp_pop;
    logic       rsp_write;
    logic       rsp_pop;
    logic       pc_write;
    logic       pc_source;
    logic       pc_add;
    logic       vala_write;
    logic       valb_write;
    logic       ir_write;
    logic       mem_read1;
    logic       mem_read2;
    logic       mem_write1;
    logic       mem_write2;
    logic [1:0] mem_dst1;
    logic [1:0] mem_dst2;
    logic [1:0] mem_data;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_t;

  // Drop every enable/strobe while keeping the select fields stable
  function automatic ctrl_t mask_enables(input ctrl_t c);
    ctrl_t m;
    m            = c;
    m.msp_write  = 1'b0;
    m.rsp_write  = 1'b0;
    m.pc_write   = 1'b0;
    m.vala_write = 1'b0;
    m.valb_write = 1'b0;
    m.ir_write   = 1'b0;
    m.mem_read1  = 1'b0;
    m.mem_read2  = 1'b0;
    m.mem_write1 = 1'b0;
    m.mem_write2 = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/control_init_timer.sv
// Post-reset settle timer: counts INIT_CYCLES-1 down to zero while enabled.
module control_init_timer #(
  parameter int unsigned INIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(INIT_CYCLES - 1);

  logic [CW-1:0] count;

  // Countdown, reloaded only by reset and parked at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LOAD;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the JALA stack CPU: fetch, decode, per-opcode execute.
module control_unit
  import control_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 5,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [15:0]      IROut,
  input  logic             ValAZero,
  input  logic             Stall,
  output logic             MSPWrite,
  output logic             MSPop,
  output logic             RSPWrite,
  output logic             RSPop,
  output logic             PCWrite,
  output logic             PCSource,
  output logic             PCAdd,
  output logic             ValAWrite,
  output logic             ValBWrite,
  output logic             IRWrite,
  output logic             MemRead1,
  output logic             MemRead2,
  output logic             MemWrite1,
  output logic             MemWrite2,
  output logic [1:0]       MemDst1,
  output logic [1:0]       MemDst2,
  output logic [1:0]       MemData,
  output logic [2:0]       ALUOp,
  output logic [CNT_W-1:0] InstrCount,
  output logic             Halted,
  output logic             IllegalOp
);

  state_t             state;
  state_t             state_nx;
  logic               init_done;
  logic               stall_eff;
  logic               illegal_c;
  logic [OPC_W-1:0]   opcode;
  logic [CNT_W-1:0]   instr_count;
  logic               illegal_q;
  ctrl_t              ctrl_raw;
  ctrl_t              ctrl;
  logic               unused_ir;

  assign opcode    = IROut[15:12];
  assign unused_ir = ^IROut[11:3];

  // Stall only freezes the sequencer once it is executing instructions
  assign stall_eff = Stall && (state != ST_INIT) && (state != ST_HALT);

  control_init_timer #(
    .INIT_CYCLES(INIT_CYCLES)
  ) u_init_timer (
    .clk  (CLK),
    .rst_n(RST_N),
    .en   (state == ST_INIT),
    .done (init_done)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_INIT;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: fetch/decode loop and one micro-sequence per opcode
  always_comb begin
    state_nx  = state;
    illegal_c = 1'b0;
    if (!stall_eff) begin
      case (state)
        ST_INIT:   if (init_done) state_nx = ST_FETCH1;
        ST_FETCH1: state_nx = ST_FETCH2;
        ST_FETCH2: state_nx = ST_DECODE;
        ST_DECODE: begin
          case (opcode)
            OP_NOP:   state_nx = ST_FETCH1;
            OP_ALU:   state_nx = ST_ALU1;
            OP_PUSHI: state_nx = ST_PSH1;
            OP_POP:   state_nx = ST_POP1;
            OP_JPOP:  state_nx = ST_JP1;
            OP_BRZ:   state_nx = ST_BR1;
            OP_CALL:  state_nx = ST_CL1;
            OP_RET:   state_nx = ST_RT1;
            OP_HALT:  state_nx = ST_HALT;
            default: begin
              state_nx  = ST_HALT;
              illegal_c = 1'b1;
            end
          endcase
        end
        ST_ALU1:   state_nx = ST_ALU2;
        ST_ALU2:   state_nx = ST_ALU3;
        ST_ALU3:   state_nx = ST_FETCH1;
        ST_PSH1:   state_nx = ST_PSH2;
        ST_PSH2:   state_nx = ST_FETCH1;
        ST_POP1:   state_nx = ST_FETCH1;
        ST_JP1:    state_nx = ST_FETCH1;
        ST_BR1:    state_nx = ST_FETCH1;
        ST_CL1:    state_nx = ST_CL2;
        ST_CL2:    state_nx = ST_FETCH1;
        ST_RT1:    state_nx = ST_RT2;
        ST_RT2:    state_nx = ST_RT3;
        ST_RT3:    state_nx = ST_FETCH1;
        ST_HALT:   state_nx = ST_HALT;
        default:   state_nx = ST_INIT;
      endcase
    end
  end

  // Output decode from state; stall suppresses enables but keeps selects
  always_comb begin
    ctrl_raw          = '0;
    ctrl_raw.mem_dst1 = DST_PC_MSP;
    ctrl_raw.mem_dst2 = DST_PC_MSP;
    ctrl_raw.mem_data = DATA_VALA;
    ctrl_raw.alu_op   = ALUOP_DEFAULT;
    case (state)
      ST_FETCH1: begin
        ctrl_raw.pc_write  = 1'b1;
        ctrl_raw.mem_read1 = 1'b1;
        ctrl_raw.mem_read2 = 1'b1;
      end
      ST_FETCH2: begin
        ctrl_raw.ir_write   = 1'b1;
        ctrl_raw.vala_write = 1'b1;
      end
      ST_ALU1: begin
        ctrl_raw.msp_write = 1'b1;
        ctrl_raw.msp_pop   = 1'b1;
        ctrl_raw.mem_read1 = 1'b1;
        ctrl_raw.mem_dst1  = DST_MSP_RSP;
        ctrl_raw.alu_op    = IROut[2:0];
      end
      ST_ALU2: begin
        ctrl_raw.valb_write = 1'b1;
        ctrl_raw.alu_op     = IROut[2:0];
      end
      ST_ALU3: begin
        ctrl_raw.mem_write1 = 1'b1;
        ctrl_raw.mem_dst1   = DST_MSP_RSP;
        ctrl_raw.mem_data   = DATA_RES;
        ctrl_raw.alu_op     = IROut[2:0];
      end
      ST_PSH1: begin
        ctrl_raw.msp_write = 1'b1;
      end
      ST_PSH2: begin
        ctrl_raw.mem_write1 = 1'b1;
        ctrl_raw.mem_dst1   = DST_MSP_RSP;
        ctrl_raw.mem_data   = DATA_ZEXT;
      end
      ST_POP1: begin
        ctrl_raw.msp_write = 1'b1;
        ctrl_raw.msp_pop   = 1'b1;
      end
      ST_JP1: begin
        ctrl_raw.pc_write  = 1'b1;
        ctrl_raw.pc_source = 1'b1;
        ctrl_raw.msp_write = 1'b1;
        ctrl_raw.msp_pop   = 1'b1;
      end
      ST_BR1: begin
        ctrl_raw.msp_write = 1'b1;
        ctrl_raw.msp_pop   = 1'b1;
        ctrl_raw.pc_write  = ValAZero;
        ctrl_raw.pc_add    = ValAZero;
      end
      ST_CL1: begin
        ctrl_raw.rsp_write = 1'b1;
      end
      ST_CL2: begin
        ctrl_raw.mem_write2 = 1'b1;
        ctrl_raw.mem_dst2   = DST_MSP_RSP;
        ctrl_raw.mem_data   = DATA_PC;
        ctrl_raw.pc_write   = 1'b1;
        ctrl_raw.pc_add     = 1'b1;
      end
      ST_RT1: begin
        ctrl_raw.mem_read2 = 1'b1;
        ctrl_raw.mem_dst2  = DST_MSP_RSP;
      end
      ST_RT2: begin
        ctrl_raw.vala_write = 1'b1;
      end
      ST_RT3: begin
        ctrl_raw.pc_write  = 1'b1;
        ctrl_raw.pc_source = 1'b1;
        ctrl_raw.rsp_write = 1'b1;
        ctrl_raw.rsp_pop   = 1'b1;
      end
      ST_HALT: begin
        ctrl_raw.halted = 1'b1;
      end
      default: ;
    endcase
    ctrl = stall_eff ? mask_enables(ctrl_raw) : ctrl_raw;
  end

  // Retired-instruction counter, bumped as each fetch completes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instr_count <= '0;
    end else if ((state == ST_FETCH2) && !stall_eff) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Sticky undefined-opcode flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      illegal_q <= 1'b0;
    end else if (illegal_c) begin
      illegal_q <= 1'b1;
    end
  end

  assign MSPWrite   = ctrl.msp_write;
  assign MSPop      = ctrl.msp_pop;
  assign RSPWrite   = ctrl.rsp_write;
  assign RSPop      = ctrl.rsp_pop;
  assign PCWrite    = ctrl.pc_write;
  assign PCSource   = ctrl.pc_source;
  assign PCAdd      = ctrl.pc_add;
  assign ValAWrite  = ctrl.vala_write;
  assign ValBWrite  = ctrl.valb_write;
  assign IRWrite    = ctrl.ir_write;
  assign MemRead1   = ctrl.mem_read1;
  assign MemRead2   = ctrl.mem_read2;
  assign MemWrite1  = ctrl.mem_write1;
  assign MemWrite2  = ctrl.mem_write2;
  assign MemDst1    = ctrl.mem_dst1;
  assign MemDst2    = ctrl.mem_dst2;
  assign MemData    = ctrl.mem_data;
  assign ALUOp      = ctrl.alu_op;
  assign Halted     = ctrl.halted;
  assign InstrCount = instr_count;
  assign IllegalOp  = illegal_q;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle control FSM for the JALA stack CPU.
- Sits directly upstream of the stage-5 datapath: drives every stack-pointer, PC, latch and memory-port enable that the datapath consumes.
- Reads back the IR and a ValA-is-zero flag from the datapath.
- Sequences fetch, decode and one execute micro-sequence per opcode.

Parameters:
INIT_CYCLES, 5, idle cycles after reset release before the first fetch (datapath settle time)
CNT_W, 16, width of the retired-instruction counter

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
IROut  input  16  current instruction from datapath IR; opcode = IROut[15:12]
ValAZero  input  1  high when datapath ValAOut == 0
Stall  input  1  freeze request from memory/debug
MSPWrite, MSPop  output  1 each  main-stack-pointer enable; MSPop=1 decrement (pop), 0 increment (push)
RSPWrite, RSPop  output  1 each  return-stack-pointer enable and direction, same encoding as MSP
PCWrite, PCSource, PCAdd  output  1 each  PC enable; PCSource=1 PC<-ValA; PCAdd=1 PC<-PC+SignExt; both 0 PC<-PC+1
ValAWrite, ValBWrite, IRWrite  output  1 each  datapath latch enables
MemRead1, MemRead2, MemWrite1, MemWrite2  output  1 each  dual-port memory strobes
MemDst1, MemDst2  output  2 each  address select: 00 PC/MSP, 01 MSP/RSP, 10 ValA
MemData  output  2  write-data select: 00 ValA, 01 ZeroExt, 10 ResOut, 11 PCOut
ALUOp  output  3  IROut[2:0] in ALU states, else 000
InstrCount  output  CNT_W  retired-instruction count
Halted  output  1  FSM in HALT
IllegalOp  output  1  sticky; set on undefined opcode

Behaviour:
- Outputs: Moore, decoded from the state register. Every output defaults to 0 unless a state lists it.
- Reset (RST_N low, any time, mid-instruction included): state <- INIT, init counter <- INIT_CYCLES-1, InstrCount <- 0, IllegalOp <- 0. All outputs go 0 immediately.
- INIT: counts down; moves to FETCH1 when the counter reaches 0. First FETCH1 occurs on the INIT_CYCLES-th edge after reset release.
- FETCH1: PCWrite, MemRead1 (MemDst1=00), MemRead2 (MemDst2=00).
- FETCH2: IRWrite, ValAWrite; InstrCount += 1, wraps at 2^CNT_W.
- DECODE: no outputs; branches on IROut[15:12].
- Opcodes and micro-sequences (each ends by returning to FETCH1):
  - 0x0 NOP: DECODE -> FETCH1.
  - 0x1 ALU: ALU1 MSPWrite, MSPop=1, MemRead1, MemDst1=01 | ALU2 ValBWrite | ALU3 MemWrite1, MemDst1=01, MemData=10.
  - 0x2 PUSHI: PSH1 MSPWrite, MSPop=0 | PSH2 MemWrite1, MemDst1=01, MemData=01.
  - 0x3 POP: POP1 MSPWrite, MSPop=1.
  - 0x4 JPOP: JP1 PCWrite, PCSource=1, MSPWrite, MSPop=1.
  - 0x5 BRZ: BR1 MSPWrite, MSPop=1; adds PCWrite, PCAdd=1 only if ValAZero=1 in BR1.
  - 0x6 CALL: CL1 RSPWrite, RSPop=0 | CL2 MemWrite2, MemDst2=01, MemData=11, PCWrite, PCAdd=1.
  - 0x7 RET: RT1 MemRead2, MemDst2=01 | RT2 ValAWrite | RT3 PCWrite, PCSource=1, RSPWrite, RSPop=1.
  - 0xF HALT: -> HALT.
  - Any other opcode: -> HALT and IllegalOp <- 1.
- HALT: Halted=1, all enables 0; left only by reset.
- Cycles per instruction, fetch to next fetch: NOP 3, POP/JPOP/BRZ 4, PUSHI/CALL 5, ALU/RET 6.
- Stall: sampled every edge. While high, the state does not advance and all enables/strobes are forced 0 (select fields hold). InstrCount does not increment. On release, the held state's outputs reassert for exactly one cycle. Stall is ignored in INIT and HALT.
- Simultaneous reset and Stall: reset wins.

Decomposition:
- Package control_pkg: opcode constants, state enum, MemDst and MemData encodings, ALUOp default.
- One sub-module, control_init_timer: INIT_CYCLES countdown with done flag.
- Everything else is a single FSM with a registered state and a combinational output decoder.

Test Plan:
- Reset release -> all outputs 0 for 5 cycles; PCWrite=MemRead1=MemRead2=1 on cycle 6; InstrCount=0.
- IROut=0x0000 stream -> FETCH1/FETCH2/DECODE repeat every 3 cycles; InstrCount=3 after 9 cycles.
- IROut=0x1003 -> ALU3 cycle shows MemWrite1=1, MemDst1=01, MemData=10, ALUOp=011; next cycle FETCH1.
- IROut=0x5000: with ValAZero=1 -> BR1 has PCWrite=PCAdd=1, MSPWrite=MSPop=1; with ValAZero=0 -> PCWrite=0, MSPWrite=1.
- IROut=0x6000 then 0x7000 -> CL2 shows MemData=11, MemDst2=01, RSPop=0; RT3 shows PCSource=1, RSPop=1.
- Stall=1 for 3 cycles during ALU2 -> ValBWrite low throughout, ValBWrite=1 for one cycle after release. IROut=0xA000 -> Halted=1, IllegalOp=1 held. RST_N pulse mid-CALL -> INIT, IllegalOp=0.
